data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data/address width; only 32 supported.
REQ-002 Parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words; power of two.
REQ-003 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  CPU presents a memory request.
REQ-007 req_ready  output  1  responder accepts the request this cycle.
REQ-008 req_wr  input  1  1 = store, 0 = load.
REQ-009 req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  CPU consumes response.
REQ-014 resp_rdata  output  32  load result, aligned and extended; 0 for stores and errors.
REQ-015 resp_err  output  1  request was misaligned or used an illegal size.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance is req_valid && req_ready at a rising edge.
REQ-018 On acceptance, the block SHALL latch wr, size, addr and wdata, load latency counter with LATENCY-1, and enter BUSY.
REQ-019 In BUSY, each edge SHALL decrement the counter; at the edge where counter==0 the FSM SHALL enter RESP, so resp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 Request inputs SHALL be ignored outside IDLE; the latched copy alone determines the operation.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready, then the FSM SHALL return to IDLE at that edge.
REQ-022 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-023 Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL set resp_err=1.
REQ-024 Size codes 011, 110, 111, and store sizes 100/101, SHALL set resp_err=1.
REQ-025 On error, no storage SHALL be modified and resp_rdata SHALL be 0.
REQ-026 A legal store SHALL commit at the BUSY->RESP edge using byte enables derived from size and addr[1:0], with data replicated to the selected lanes; unselected bytes SHALL be unchanged.
REQ-027 A legal load SHALL read the word at the BUSY->RESP edge.
REQ-027a The loaded byte/half SHALL be selected by addr[1:0]; B/H SHALL sign-extend and BU/HU SHALL zero-extend; W is passed through.
REQ-028 A store's resp_rdata SHALL be 0 and resp_err SHALL be 0.
REQ-029 The earliest next acceptance after a response handshake SHALL be the following cycle, since req_ready returns to 1 in IDLE.

Reset
REQ-030 While rst=0, the FSM SHALL be IDLE, the counter and latched request SHALL be 0, req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-031 Reset asserted in BUSY or RESP SHALL abort the operation; a store not yet committed SHALL never be written.
REQ-032 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-033 A shared package SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the state enum, for reuse by the CPU decoder.
REQ-034 Load lane selection and extension SHALL be a combinational sub-module, mem_load_align; storage, byte-enable generation and the FSM SHALL live in the top module.

Verification
REQ-035 Store W 0xDEADBEEF at addr 0x10, then load W at 0x10. Required: resp_valid exactly LATENCY cycles after each acceptance, and rdata=0xDEADBEEF.
REQ-036 Store B 0x80 at 0x13, then load B and BU at 0x13. Required: B returns 0xFFFFFF80, BU returns 0x00000080, and a load W at 0x10 returns 0x80ADBEEF.
REQ-037 Load H at 0x11. Required: resp_err=1 and rdata=0. A store W at 0x12 SHALL give resp_err=1 and leave word 0x10 unchanged.
REQ-038 Hold resp_ready=0 for 5 cycles in RESP. Required: outputs stable, req_ready=0, and a new req_valid is ignored; after the handshake, req_ready=1 next cycle.
REQ-039 Assert rst mid-BUSY on a store W 0x12345678 at 0x20 (pre-existing 0). Required: outputs return to reset values, and a subsequent load at 0x20 returns 0.
REQ-040 With DEPTH_WORDS=1024, store W 0xA5A5A5A5 at 0x1000, then load W at 0x0. Required: 0xA5A5A5A5 (address wrap).

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// data_mem_responder_pkg : size encodings and FSM state type for the data
// memory responder and the CPU decoder.   Rev 1.0
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_mem_load_align.sv
// ============================================================================
// mem_load_align : selects the loaded byte/half lane from a 32-bit word and
// sign- or zero-extends it.   Rev 1.0
// ============================================================================
`default_nettype none

module mem_load_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  assign w_byte     = i_word[8*i_addr_lo +: 8];
  assign w_half     = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  assign w_unsigned = i_size[2];

  // Illegal codes fall through to the word path; the caller zeroes them.
  always_comb begin
    o_data = i_word;
    case (i_size[1:0])
      2'b00:   o_data = {{24{w_byte[7] & ~w_unsigned}}, w_byte};
      2'b01:   o_data = {{16{w_half[15] & ~w_unsigned}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : fixed-latency byte-addressable data memory with a
// valid/ready request and response handshake.   Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int         c_AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_wr;
  logic [2:0]      r_size;
  logic [c_AW+1:0] r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_resp_rdata;
  logic            r_resp_err;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_err;
  logic            w_commit;
  logic            w_we;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata_rep;
  logic [31:0]     w_word;
  logic [31:0]     w_load_data;
  logic            w_unused_addr;

  // Addresses wrap modulo the storage size, so upper bits are dropped.
  assign w_unused_addr = ^req_addr[DATA_WIDTH-1:c_AW+2];

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  always_comb begin
    w_err = 1'b1;
    case (r_size)
      SZ_B:  w_err = 1'b0;
      SZ_BU: w_err = r_wr;
      SZ_H:  w_err = r_addr[0];
      SZ_HU: w_err = r_addr[0] | r_wr;
      SZ_W:  w_err = |r_addr[1:0];
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = r_wdata;
    case (r_size[1:0])
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  assign w_commit = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_we     = w_commit && r_wr && !w_err;
  assign w_word   = r_mem[r_addr[c_AW+1:2]];

  mem_load_align u_load_align (
    .i_word    (w_word),
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .o_data    (w_load_data)
  );

  // Storage has no reset; the FSM reset alone prevents an aborted commit.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we && w_be[b]) begin
        r_mem[r_addr[c_AW+1:2]][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_wr         <= 1'b0;
      r_size       <= 3'd0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_wr    <= req_wr;
            r_size  <= req_size;
            r_addr  <= req_addr[c_AW+1:0];
            r_wdata <= req_wdata;
            r_cnt   <= c_LAT_M1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state      <= ST_RESP;
            r_resp_err   <= w_err;
            r_resp_rdata <= (w_err || r_wr) ? 32'd0 : w_load_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : directed self-checking bench for data_mem_responder.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request at a negedge, accepted at the next posedge; waits for the
  // response, checks latency and payload. Response is left pending if hold=1.
  task automatic issue(input string tag, input logic wr, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic hold);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF; req_addr = 32'h0;
    chk({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
    cyc = 0;
    while (cyc < 20 && resp_valid !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, LATENCY);
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    if (!hold) begin
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Word store then load
    issue("stw10", 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    issue("ldw10", 1'b0, SZ_W, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Byte store at lane 3, sign/zero-extended loads
    issue("stb13", 1'b1, SZ_B, 32'h13, 32'h1234_5680, 32'h0, 1'b0, 1'b0);
    issue("ldb13", 1'b0, SZ_B, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
    issue("ldbu13", 1'b0, SZ_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
    issue("ldw10b", 1'b0, SZ_W, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b0);
    issue("ldh12", 1'b0, SZ_H, 32'h12, 32'h0, 32'hFFFF_80AD, 1'b0, 1'b0);
    issue("ldhu12", 1'b0, SZ_HU, 32'h12, 32'h0, 32'h0000_80AD, 1'b0, 1'b0);
    issue("ldb10", 1'b0, SZ_B, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, 1'b0);
    issue("ldbu11", 1'b0, SZ_BU, 32'h11, 32'h0, 32'h0000_00BE, 1'b0, 1'b0);

    // Errors: misaligned, illegal sizes; storage untouched
    issue("ldh11", 1'b0, SZ_H, 32'h11, 32'h0, 32'h0, 1'b1, 1'b0);
    issue("stw12", 1'b1, SZ_W, 32'h12, 32'h1111_1111, 32'h0, 1'b1, 1'b0);
    issue("sthu10", 1'b1, SZ_HU, 32'h10, 32'h2222_2222, 32'h0, 1'b1, 1'b0);
    issue("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    issue("ld111", 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    issue("ldw10c", 1'b0, SZ_W, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b0);

    // Half store to upper lane
    issue("sth12", 1'b1, SZ_H, 32'h12, 32'hABCD_1234, 32'h0, 1'b0, 1'b0);
    issue("ldw10d", 1'b0, SZ_W, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0, 1'b0);

    // Backpressure: response held 5 cycles while a store is offered
    issue("bp", 1'b0, SZ_W, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0, 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = SZ_W; req_addr = 32'h10; req_wdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, 32'h1234_BEEF);
      chk("bp_err", {31'd0, resp_err}, 32'd0);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk); req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("bp_ready_after", {31'd0, req_ready}, 32'd1);
    chk("bp_valid_after", {31'd0, resp_valid}, 32'd0);
    issue("ldw10e", 1'b0, SZ_W, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0, 1'b0);

    // Reset mid-BUSY aborts an uncommitted store
    issue("stw20z", 1'b1, SZ_W, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = SZ_W; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_err", {31'd0, resp_err}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    issue("ldw20", 1'b0, SZ_W, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    issue("ldw10f", 1'b0, SZ_W, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0, 1'b0);

    // Address wrap
    issue("stw1000", 1'b1, SZ_W, 32'h1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
    issue("ldw0", 1'b0, SZ_W, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
